// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read path: FSM encodings, default widths
// and the sdram_read command constants.
package sdram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_END = 2'd2
  } rd_state_e;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_AREF      = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

endpackage

// File: rtl/sdram_rd_buf_if.sv
// Bundle of the sdram_read request/return signals and the consumer read port.
interface sdram_rd_buf_if
  import sdram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = 10
) ();

  logic                  init_end;
  logic                  rd_valid;
  logic                  rd_rst;
  logic [ADDR_W-1:0]     rd_b_addr;
  logic [ADDR_W-1:0]     rd_e_addr;
  logic [LEN_W-1:0]      rd_len;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [LEN_W-1:0]      rd_burst_len;
  logic                  rd_ack;
  logic [DATA_W-1:0]     rd_sdram_data;
  logic                  rd_end;
  logic                  buf_rd_en;
  logic [DATA_W-1:0]     buf_rd_data;
  logic [DEPTH_LOG2:0]   buf_num;
  logic                  buf_empty;
  logic                  buf_ovf;

  modport master (
    input  init_end, rd_valid, rd_rst, rd_b_addr, rd_e_addr, rd_len,
    input  rd_ack, rd_sdram_data, rd_end, buf_rd_en,
    output rd_en, rd_addr, rd_burst_len, buf_rd_data, buf_num, buf_empty, buf_ovf
  );

  modport slave (
    output init_end, rd_valid, rd_rst, rd_b_addr, rd_e_addr, rd_len,
    output rd_ack, rd_sdram_data, rd_end, buf_rd_en,
    input  rd_en, rd_addr, rd_burst_len, buf_rd_data, buf_num, buf_empty, buf_ovf
  );

endinterface

// File: rtl/sdram_rd_fifo.sv
// Single-clock FIFO with flush, registered read data, count, empty and full.
module sdram_rd_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_W-1:0]     pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic                  do_push_s;
  logic                  do_pop_s;
  logic [DEPTH_LOG2:0]   count_nxt_s;

  // Qualified push/pop and the resulting fill level.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count + (DEPTH_LOG2+1)'(1);
      2'b01:   count_nxt_s = count - (DEPTH_LOG2+1)'(1);
      default: count_nxt_s = count;
    endcase
  end

  // Storage array; flush discards the word presented on the same edge.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, status and the registered read word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      pop_data <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
        pop_data <= mem_r[rd_ptr_r];
      end
      count <= count_nxt_s;
      empty <= (count_nxt_s == '0);
      full  <= (count_nxt_s == FULL_CNT);
    end
  end

endmodule

// File: rtl/sdram_rd_buf.sv
// Prefetching read buffer in front of sdram_read: walks a circular address
// window in bursts whenever the FIFO has room for a whole burst.
module sdram_rd_buf
  import sdram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  sdram_rd_buf_if.master  bus
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam int NXT_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] CAPACITY = SUM_W'(1) << DEPTH_LOG2;

  rd_state_e          state_r;
  logic               rd_en_r;
  logic [ADDR_W-1:0]  rd_addr_r;
  logic [ADDR_W-1:0]  next_addr_r;
  logic [LEN_W-1:0]   rd_burst_len_r;
  logic               need_load_r;
  logic               discard_r;
  logic               buf_ovf_r;

  logic               push_s;
  logic               fit_s;
  logic               start_s;
  logic               wrap_s;
  logic [NXT_W-1:0]   nxt_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic [DATA_W-1:0]  fifo_data_s;

  // Request gating, FIFO write qualification and next-burst address.
  always_comb begin
    push_s  = bus.rd_ack && !discard_r && !bus.rd_rst && (state_r != ST_IDLE);
    fit_s   = (SUM_W'(fifo_count_s) + SUM_W'(bus.rd_len)) <= CAPACITY;
    start_s = bus.init_end && bus.rd_valid && (bus.rd_len != LEN_W'(0))
              && !bus.rd_rst && fit_s;
    nxt_s   = {1'b0, rd_addr_r} + NXT_W'(rd_burst_len_r);
    wrap_s  = nxt_s >= {1'b0, bus.rd_e_addr};
  end

  // Burst request FSM with registered request outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r        <= ST_IDLE;
      rd_en_r        <= 1'b0;
      rd_addr_r      <= '0;
      next_addr_r    <= '0;
      rd_burst_len_r <= '0;
      need_load_r    <= 1'b1;
      discard_r      <= 1'b0;
    end else begin
      if (bus.rd_rst) begin
        need_load_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r        <= ST_REQ;
            rd_en_r        <= 1'b1;
            rd_burst_len_r <= bus.rd_len;
            rd_addr_r      <= need_load_r ? bus.rd_b_addr : next_addr_r;
            need_load_r    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.rd_rst) begin
            discard_r <= 1'b1;
          end
          if (bus.rd_ack) begin
            rd_en_r <= 1'b0;
            state_r <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          if (bus.rd_end) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
            // A flushed burst leaves the address alone; need_load reloads it.
            if (!discard_r && !bus.rd_rst) begin
              next_addr_r <= wrap_s ? bus.rd_b_addr : nxt_s[ADDR_W-1:0];
            end
          end else if (bus.rd_rst) begin
            discard_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a returned word arrived while the FIFO was full.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      buf_ovf_r <= 1'b0;
    end else if (bus.rd_rst) begin
      buf_ovf_r <= 1'b0;
    end else if (push_s && fifo_full_s) begin
      buf_ovf_r <= 1'b1;
    end
  end

  sdram_rd_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push_s),
    .push_data (bus.rd_sdram_data),
    .pop       (bus.buf_rd_en),
    .flush     (bus.rd_rst),
    .pop_data  (fifo_data_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign bus.rd_en        = rd_en_r;
  assign bus.rd_addr      = rd_addr_r;
  assign bus.rd_burst_len = rd_burst_len_r;
  assign bus.buf_rd_data  = fifo_data_s;
  assign bus.buf_num      = fifo_count_s;
  assign bus.buf_empty    = fifo_empty_s;
  assign bus.buf_ovf      = buf_ovf_r;

endmodule

// File: tb/tb_sdram_rd_buf.sv
// Directed bench for sdram_rd_buf with a 16-deep FIFO so that backpressure
// and overflow are reachable with 10-word bursts.
module tb_sdram_rd_buf;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sdram_rd_buf_if #(.DATA_W(16), .ADDR_W(24), .DEPTH_LOG2(4)) bus_if ();

  sdram_rd_buf #(.DATA_W(16), .ADDR_W(24), .DEPTH_LOG2(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rd_en(input string tag);
    int n;
    n = 0;
    while (bus_if.rd_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, bus_if.rd_en}, 32'd1);
  endtask

  task automatic acks(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      bus_if.rd_ack        = 1'b1;
      bus_if.rd_sdram_data = base + 16'(i);
      tick();
    end
    bus_if.rd_ack = 1'b0;
  endtask

  task automatic end_burst();
    bus_if.rd_end = 1'b1;
    tick();
    bus_if.rd_end = 1'b0;
  endtask

  task automatic drain(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      bus_if.buf_rd_en = 1'b1;
      tick();
      check_eq("pop_data", {16'd0, bus_if.buf_rd_data}, {16'd0, base + 16'(i)});
    end
    bus_if.buf_rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"},   {31'd0, bus_if.rd_en},        32'd0);
    check_eq({tag, "_addr"},    {8'd0, bus_if.rd_addr},       32'd0);
    check_eq({tag, "_blen"},    {22'd0, bus_if.rd_burst_len}, 32'd0);
    check_eq({tag, "_data"},    {16'd0, bus_if.buf_rd_data},  32'd0);
    check_eq({tag, "_num"},     {27'd0, bus_if.buf_num},      32'd0);
    check_eq({tag, "_empty"},   {31'd0, bus_if.buf_empty},    32'd1);
    check_eq({tag, "_ovf"},     {31'd0, bus_if.buf_ovf},      32'd0);
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_if.init_end = 1'b0;  bus_if.rd_valid = 1'b0;  bus_if.rd_rst = 1'b0;
    bus_if.rd_b_addr = 24'h000100;  bus_if.rd_e_addr = 24'h000200;
    bus_if.rd_len = 10'd10;  bus_if.rd_ack = 1'b0;  bus_if.rd_sdram_data = 16'h0000;
    bus_if.rd_end = 1'b0;  bus_if.buf_rd_en = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // gating: init_end low, then rd_len zero with a stray ack in IDLE
    bus_if.rd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= bus_if.rd_en; end
    check_eq("gate_init", {31'd0, seen}, 32'd0);
    bus_if.init_end = 1'b1;
    bus_if.rd_len   = 10'd0;
    bus_if.rd_ack   = 1'b1;
    tick();
    bus_if.rd_ack   = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= bus_if.rd_en; end
    check_eq("gate_len0", {31'd0, seen}, 32'd0);
    check_eq("stray_ack_num", {27'd0, bus_if.buf_num}, 32'd0);

    // basic burst
    bus_if.rd_len = 10'd10;
    wait_rd_en("req1");
    check_eq("req1_addr", {8'd0, bus_if.rd_addr}, 32'h000100);
    check_eq("req1_blen", {22'd0, bus_if.rd_burst_len}, 32'd10);
    acks(10, 16'hA000);
    end_burst();
    check_eq("burst1_num", {27'd0, bus_if.buf_num}, 32'd10);
    check_eq("burst1_empty", {31'd0, bus_if.buf_empty}, 32'd0);

    // backpressure: 10 + 10 > 16, so no request until the level drops to 6
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= bus_if.rd_en; end
    check_eq("bp_no_req", {31'd0, seen}, 32'd0);
    check_eq("bp_num", {27'd0, bus_if.buf_num}, 32'd10);
    drain(3, 16'hA000);
    check_eq("bp_num7", {27'd0, bus_if.buf_num}, 32'd7);
    check_eq("bp_rd_en7", {31'd0, bus_if.rd_en}, 32'd0);
    drain(1, 16'hA003);
    check_eq("bp_num6", {27'd0, bus_if.buf_num}, 32'd6);
    wait_rd_en("req2");
    check_eq("req2_addr", {8'd0, bus_if.rd_addr}, 32'h00010A);

    // push and pop on the same edge
    bus_if.rd_ack = 1'b1;
    bus_if.rd_sdram_data = 16'hB000;
    bus_if.buf_rd_en = 1'b1;
    tick();
    bus_if.buf_rd_en = 1'b0;
    check_eq("pushpop_num", {27'd0, bus_if.buf_num}, 32'd6);
    check_eq("pushpop_data", {16'd0, bus_if.buf_rd_data}, 32'h0000A004);
    acks(9, 16'hB001);
    end_burst();
    bus_if.rd_valid = 1'b0;
    check_eq("burst2_num", {27'd0, bus_if.buf_num}, 32'd15);
    drain(5, 16'hA005);
    drain(10, 16'hB000);
    check_eq("drained_empty", {31'd0, bus_if.buf_empty}, 32'd1);
    bus_if.buf_rd_en = 1'b1;
    tick(); tick();
    bus_if.buf_rd_en = 1'b0;
    check_eq("empty_pop_data", {16'd0, bus_if.buf_rd_data}, 32'h0000B009);
    check_eq("empty_pop_num", {27'd0, bus_if.buf_num}, 32'd0);

    // address wrap in [0x00, 0x14)
    bus_if.rd_b_addr = 24'h000000;
    bus_if.rd_e_addr = 24'h000014;
    bus_if.rd_rst = 1'b1;
    tick();
    bus_if.rd_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_if.rd_valid = 1'b1;
      wait_rd_en("wrap_req");
      check_eq("wrap_addr", {8'd0, bus_if.rd_addr}, (k == 1) ? 32'h00000A : 32'h000000);
      bus_if.rd_valid = 1'b0;
      acks(10, 16'h1000 + 16'(k * 256));
      end_burst();
      if (k < 2) drain(10, 16'h1000 + 16'(k * 256));
    end

    // overflow: level 10, 6-word request answered with 7 words
    bus_if.rd_len = 10'd6;
    bus_if.rd_valid = 1'b1;
    wait_rd_en("ovf_req");
    check_eq("ovf_addr", {8'd0, bus_if.rd_addr}, 32'h00000A);
    check_eq("ovf_blen", {22'd0, bus_if.rd_burst_len}, 32'd6);
    bus_if.rd_valid = 1'b0;
    acks(7, 16'h1300);
    end_burst();
    check_eq("ovf_num", {27'd0, bus_if.buf_num}, 32'd16);
    check_eq("ovf_flag", {31'd0, bus_if.buf_ovf}, 32'd1);
    bus_if.rd_rst = 1'b1;
    tick();
    bus_if.rd_rst = 1'b0;
    check_eq("flush_num", {27'd0, bus_if.buf_num}, 32'd0);
    check_eq("flush_empty", {31'd0, bus_if.buf_empty}, 32'd1);
    check_eq("flush_ovf", {31'd0, bus_if.buf_ovf}, 32'd0);

    // flush after 3 of 10 words
    bus_if.rd_b_addr = 24'h000100;
    bus_if.rd_e_addr = 24'h000200;
    bus_if.rd_len = 10'd10;
    bus_if.rd_valid = 1'b1;
    wait_rd_en("fl_req");
    check_eq("fl_addr", {8'd0, bus_if.rd_addr}, 32'h000100);
    acks(3, 16'hC000);
    bus_if.rd_rst = 1'b1;
    bus_if.rd_ack = 1'b1;
    bus_if.rd_sdram_data = 16'hC003;
    tick();
    bus_if.rd_rst = 1'b0;
    check_eq("fl_num_now", {27'd0, bus_if.buf_num}, 32'd0);
    acks(6, 16'hC004);
    end_burst();
    check_eq("fl_num_end", {27'd0, bus_if.buf_num}, 32'd0);
    check_eq("fl_empty_end", {31'd0, bus_if.buf_empty}, 32'd1);
    wait_rd_en("fl_req2");
    check_eq("fl_reload_addr", {8'd0, bus_if.rd_addr}, 32'h000100);
    acks(10, 16'hD000);
    end_burst();
    check_eq("fl_after_num", {27'd0, bus_if.buf_num}, 32'd10);
    drain(1, 16'hD000);

    // reset while waiting for rd_end
    bus_if.rd_len = 10'd4;
    wait_rd_en("rst_req");
    check_eq("rst_req_addr", {8'd0, bus_if.rd_addr}, 32'h00010A);
    acks(1, 16'hE000);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    bus_if.rd_valid = 1'b0;
    bus_if.rd_ack = 1'b1;
    bus_if.rd_end = 1'b1;
    tick();
    bus_if.rd_ack = 1'b0;
    bus_if.rd_end = 1'b0;
    tick();
    check_eq("stray_num", {27'd0, bus_if.buf_num}, 32'd0);
    check_eq("stray_rd_en", {31'd0, bus_if.rd_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_rd_buf.md
Name: sdram_rd_buf

Overview:
- Read-side buffer stage that sits directly upstream of sdram_read.
- Issues read-burst requests to sdram_read (rd_en, rd_addr, rd_burst_len) whenever its internal FIFO has room for a whole burst.
- Captures the returned words on rd_ack into the FIFO and presents them to a downstream consumer (e.g. the UART TX path) through a simple read port.
- Walks a circular address window [rd_b_addr, rd_e_addr) in steps of one burst.

Parameters:
- DATA_W, 16, SDRAM data width.
- ADDR_W, 24, SDRAM linear address width ({ba[1:0], row[12:0], col[8:0]}).
- DEPTH_LOG2, 10, log2 of FIFO depth (1024 words).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- init_end  in  1  SDRAM initialisation complete; no request is issued while it is 0.
- rd_valid  in  1  level enable for prefetching.
- rd_rst  in  1  one-cycle pulse: flush the FIFO and reload the address from rd_b_addr.
- rd_b_addr  in  ADDR_W  window base address.
- rd_e_addr  in  ADDR_W  window end address (exclusive).
- rd_len  in  10  burst length in words; 0 disables requests.
- rd_en  out  1  request to sdram_read.
- rd_addr  out  ADDR_W  burst start address.
- rd_burst_len  out  10  latched burst length.
- rd_ack  in  1  data-valid strobe from sdram_read.
- rd_sdram_data  in  DATA_W  data from sdram_read, valid when rd_ack=1.
- rd_end  in  1  burst-complete pulse from sdram_read.
- buf_rd_en  in  1  consumer pop request.
- buf_rd_data  out  DATA_W  popped word.
- buf_num  out  DEPTH_LOG2+1  FIFO fill level.
- buf_empty  out  1  FIFO empty.
- buf_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - Outputs: rd_en=0, rd_addr=0, rd_burst_len=0, buf_rd_data=0, buf_num=0, buf_empty=1, buf_ovf=0.
  - Internal: FSM=IDLE, need_load=1, discard=0.
  - Reset asserted mid-burst aborts everything. Any stray rd_ack/rd_end seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_END.
- IDLE → REQ when init_end=1, rd_valid=1, rd_len!=0, rd_rst=0, and buf_num + rd_len <= 2^DEPTH_LOG2 (compare at 11 bits, no overflow).
  - On this transition: rd_burst_len <= rd_len.
  - On this transition: rd_addr <= rd_b_addr if need_load=1, else the stored next address. need_load is then cleared.
  - rd_en <= 1 on the same edge, so rd_en first appears the cycle after the condition holds.
- REQ: hold rd_en=1 until the first rd_ack. On that cycle, rd_en <= 0 and the FSM goes to WAIT_END.
- WAIT_END: on rd_end, compute nxt = rd_addr + rd_burst_len in 25-bit arithmetic.
  - If nxt >= rd_e_addr, the next address is rd_b_addr (wrap); otherwise it is nxt.
  - The FSM then returns to IDLE.
  - The earliest possible re-request is on the cycle after rd_end.
- rd_burst_len and rd_addr stay stable from IDLE→REQ until the next IDLE→REQ. Changes to rd_len or rd_b_addr mid-burst have no effect on the burst in progress.
- FIFO write: on rd_ack=1 with discard=0.
  - If the FIFO is full, the word is dropped and buf_ovf is set. buf_ovf is cleared only by reset or rd_rst.
- FIFO read: registered output. buf_rd_en=1 with buf_empty=0 pops, and buf_rd_data updates at the next edge. buf_rd_en while empty is ignored and buf_rd_data holds its value.
- Simultaneous push and pop: buf_num unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- buf_num and buf_empty are registered and reflect the state after the current edge's push/pop.
- rd_rst in IDLE: flush (pointers, buf_num = 0, buf_empty=1, buf_ovf=0), set need_load=1, and block a request that cycle.
- rd_rst in REQ or WAIT_END: flush immediately, set need_load=1, set discard=1.
  - The in-flight burst still runs to rd_end, with all of its words discarded and the address not advanced.
  - discard clears on rd_end.
- rd_rst together with a pop: the flush wins.

Decomposition:
- Shared package sdram_pkg: FSM state encodings, the DATA_W/ADDR_W defaults, and the sdram_read command constants already used across the controller.
- One sub-module, sdram_rd_fifo: synchronous single-clock FIFO with push, pop, flush, registered read data, count, empty and full.

Test Plan:
- Basic burst: reset, init_end=1, rd_b_addr=0x000100, rd_e_addr=0x000200, rd_len=10, rd_valid=1, bus model returns words 0xA000..0xA009 → rd_addr=0x000100, rd_burst_len=10, buf_num=10, popping yields 0xA000..0xA009 in order.
- Address wrap: rd_b_addr=0x000000, rd_e_addr=0x000014, rd_len=10 → rd_addr sequence 0x000000, 0x00000A, 0x000000.
- Backpressure: DEPTH_LOG2=4, rd_len=10, no pops → one burst only; buf_num stays 10 and rd_en stays 0 until buf_num<=6 after 4 pops, then the next request is issued.
- Flush mid-burst: rd_rst pulsed after 3 of 10 rd_ack → buf_num=0, the remaining 7 words are discarded, the next request uses rd_b_addr again.
- Simultaneous push/pop: buf_num=5 with buf_rd_en=1 during an rd_ack cycle → buf_num stays 5; popping when empty leaves buf_rd_data unchanged.
- Gating and reset: init_end=0 or rd_len=0 → rd_en never asserts; sys_rst_n=0 during WAIT_END → all outputs return to reset values on the next edge.
